echo_engine: RTL and testbench
==============================

# echo_engine

Parametrised successor to the single-line echo handler for the bash I/O path. It sits between the video-memory bash interface and the command layer, and handles one command end to end:
- Receives up to `LINES` input lines, each into a `BUFFER_LEN`-byte buffer.
- Echoes each line `REPEAT` times, optionally reversed and upper-cased.
- Raises `in_solved` when the command completes.

New over the fixed three-line echo: configurable line count, repeat count and reverse mode, explicit overflow truncation with a status flag, and a synchronous reset. Signal directions are named from the video-memory point of view.

## Interface
- `BUFFER_LEN`, 128: line buffer depth in bytes. Must be ≥ 1 and ≤ 2^LEN_W − 1.
- `LEN_W`, 13: width of the length and index counters.
- `LINES`, 3: input lines consumed per command before `in_solved`. Must be ≥ 1.
- `REPEAT`, 1: number of times each received line is echoed. Must be ≥ 1.
- `REVERSE`, 0: 0 = echo in forward order; 1 = echo in reversed byte order.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous reset, active-low.
- `in_solved` out 1: command finished; held until `out_solved`.
- `out_solved` in 1: one-cycle acknowledge of `in_solved`.
- `in_require_line` out 1: request for the next input line; held until `out_require_line`.
- `out_require_line` in 1: one-cycle acknowledge of `in_require_line`.
- `lineIn_nextASCII` in 1: consumer took the current `lineIn` byte.
- `in_newASCII_ready` out 1: an echo line is being presented.
- `lineIn` out 8: echo byte; 0x00 terminates the line.
- `lineOut_nextASCII` out 1: one-cycle pulse; input byte consumed.
- `out_newASCII_ready` in 1: input line transfer in progress.
- `out_lineLen` in 13: announced input length. Informational only; not used for control.
- `lineOut` in 8: input byte; 0x00 terminates the line.
- `line_truncated` out 1: sticky flag; the last received line exceeded `BUFFER_LEN`.

## Operation
- States: `S_RECV`, `S_SEND`, `S_GAP`, `S_DONE`. Reset state is `S_RECV`.
- **`S_RECV`**
  - When `out_newASCII_ready=1` and `lineOut_nextASCII=0`: sample `lineOut` and assert `lineOut_nextASCII` for exactly one cycle.
  - Non-zero byte with `wr_len < BUFFER_LEN`: store at `buffer[wr_len]`; `wr_len++`.
  - Non-zero byte with the buffer full: drop the byte; set `line_truncated`; `wr_len` saturates.
  - Zero byte: `rd_idx ← 0`, `rep ← 0`, go to `S_SEND`.
  - `line_truncated` clears when the first byte of the next line is sampled.
- **`S_SEND`**
  - Stalls with `in_newASCII_ready=0` while `out_newASCII_ready=1`. Otherwise `in_newASCII_ready=1`.
  - `lineIn` = 0x00 when `rd_idx == wr_len`.
  - Otherwise `lineIn` = `buffer[rd_idx]` (REVERSE=0) or `buffer[wr_len−1−rd_idx]` (REVERSE=1).
  - `lineIn_nextASCII=1` with `rd_idx < wr_len`: `rd_idx++`.
  - With `rd_idx == wr_len`, the next edge ends the pass. The terminator is presented for exactly one cycle, and `lineIn_nextASCII` is not required.
  - End of pass, `rep < REPEAT−1`: `rep++`, `rd_idx ← 0`, go to `S_GAP`.
  - End of the last pass: `wr_len ← 0`, `in_newASCII_ready ← 0`.
    - If `line_cnt == LINES−1`: `line_cnt ← 0`, `in_solved ← 1`, go to `S_DONE`.
    - Otherwise: `line_cnt++`, `in_require_line ← 1`, go to `S_RECV`.
- **`S_GAP`**: one cycle with `in_newASCII_ready=0`, then back to `S_SEND`.
- **`S_DONE`**: on `out_solved`, `in_solved ← 0` and go to `S_RECV`.
- `in_require_line` clears on `out_require_line` in any state. This acknowledge has priority over nothing else and may coincide with input bytes.
- Empty line (`wr_len=0`): each pass is the terminator alone.
- `lineIn` is combinational from `rd_idx`, `wr_len` and the buffer.

## Timing
- Reset values, with `rst_n=0` sampled at an edge:
  - `in_solved`, `in_require_line`, `in_newASCII_ready`, `lineOut_nextASCII`, `line_truncated` = 0.
  - `wr_len`, `rd_idx`, `rep`, `line_cnt` = 0; state `S_RECV`.
  - Buffer contents are not reset.
- Reset mid-transfer aborts the current line and command with no acknowledge pending.
- Input throughput: 1 byte per 2 cycles (pulse, then a low cycle).
- Echo start: the first cycle with `out_newASCII_ready=0` after the terminator is sampled.
- Echo pass latency with a consumer pulsing every cycle: `wr_len+1` cycles.
- `in_solved` rises the edge after the final terminator cycle.

## Configuration
- `ECHO_UPPERCASE_EN` defined: echoed bytes 0x61–0x7A are output minus 0x20. Buffer contents are unchanged.
- `ECHO_UPPERCASE_EN` undefined: bytes pass unmodified.
- The terminator 0x00 is never altered in either case.

## Test plan
- **Basic echo**: LINES=1, REPEAT=1; send "ab",00 → `lineIn` gives 0x61, 0x62, 0x00 (terminator for 1 cycle) → `in_solved=1` until `out_solved`.
- **Repeat and reverse**: REPEAT=2, REVERSE=1; send "xyz" → two passes "zyx",00 separated by one `in_newASCII_ready=0` cycle.
- **Overflow**: BUFFER_LEN=4; send "abcdef" → echo "abcd",00 and `line_truncated=1`.
- **Multi-line**: LINES=3 → `in_require_line` asserted after lines 1 and 2 and cleared by `out_require_line`; `in_solved` only after line 3.
- **Uppercase**: with `ECHO_UPPERCASE_EN`, "aZ1" → 0x41, 0x5A, 0x31, 0x00; without it → 0x61, 0x5A, 0x31, 0x00.
- **Reset mid-send**: `rst_n=0` during `S_SEND` → all outputs 0 next cycle; a new line then echoes correctly.

Source files
------------

// File: rtl/echo_engine.sv
// echo_engine: receives LINES input lines and echoes each one REPEAT times, optionally reversed.
// Optional feature: define ECHO_UPPERCASE_EN to upper-case echoed bytes 0x61-0x7A.
module echo_engine #(
   parameter int BUFFER_LEN = 128,
   parameter int LEN_W      = 13,
   parameter int LINES      = 3,
   parameter int REPEAT     = 1,
   parameter int REVERSE    = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             in_solved,
   input  logic             out_solved,
   output logic             in_require_line,
   input  logic             out_require_line,
   input  logic             lineIn_nextASCII,
   output logic             in_newASCII_ready,
   output logic [7:0]       lineIn,
   output logic             lineOut_nextASCII,
   input  logic             out_newASCII_ready,
   input  logic [LEN_W-1:0] out_lineLen,
   input  logic [7:0]       lineOut,
   output logic             line_truncated
);

   localparam int AW    = (BUFFER_LEN > 1) ? $clog2(BUFFER_LEN) : 1;
   localparam int DEPTH = 1 << AW;
   localparam int CNT_W = 16;
   localparam bit REV   = (REVERSE != 0);

   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
   localparam logic [LEN_W-1:0] BUF_MAX   = LEN_W'(BUFFER_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT - 1);
   localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINES - 1);

   typedef enum logic [1:0] {
      S_RECV,
      S_SEND,
      S_GAP,
      S_DONE
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] wr_len;
   logic [LEN_W-1:0] rd_idx;
   logic [CNT_W-1:0] rep;
   logic [CNT_W-1:0] line_cnt;
   logic [7:0]       buffer [DEPTH];

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [7:0]       rd_byte;
   logic             sample;
   logic             store;
   logic             pass_end;
   logic             unused_len;

   function automatic logic [7:0] to_echo(input logic [7:0] b);
`ifdef ECHO_UPPERCASE_EN
      if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
      return b;
`else
      return b;
`endif
   endfunction

   // The announced length is advisory; the 0x00 terminator alone delimits a line.
   assign unused_len = ^out_lineLen;

   assign sample            = (state == S_RECV) && out_newASCII_ready && !lineOut_nextASCII;
   assign store             = sample && (lineOut != 8'h00) && (wr_len < BUF_MAX);
   assign in_newASCII_ready = (state == S_SEND) && !out_newASCII_ready;
   assign pass_end          = in_newASCII_ready && (rd_idx == wr_len);
   assign wr_ptr            = AW'(wr_len);
   assign rd_ptr            = REV ? AW'(wr_len - rd_idx - LEN_ONE) : AW'(rd_idx);

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      rd_byte = buffer[rd_ptr];
      lineIn  = 8'h00;
      if (rd_idx != wr_len) lineIn = to_echo(rd_byte);
   end

   // NOTE: the line buffer is deliberately not reset; wr_len/rd_idx define which entries are live.
   always_ff @(posedge clk) begin
      if (rst_n && store) buffer[wr_ptr] <= lineOut;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= S_RECV;
         wr_len            <= '0;
         rd_idx            <= '0;
         rep               <= '0;
         line_cnt          <= '0;
         in_solved         <= 1'b0;
         in_require_line   <= 1'b0;
         lineOut_nextASCII <= 1'b0;
         line_truncated    <= 1'b0;
      end else begin
         lineOut_nextASCII <= 1'b0;
         if (out_require_line) in_require_line <= 1'b0;

         case (state)
            S_RECV: begin
               if (sample) begin
                  lineOut_nextASCII <= 1'b1;
                  if (wr_len == '0) line_truncated <= 1'b0;
                  if (lineOut == 8'h00) begin
                     rd_idx <= '0;
                     rep    <= '0;
                     state  <= S_SEND;
                  end else if (wr_len < BUF_MAX) begin
                     wr_len <= wr_len + LEN_ONE;
                  end else begin
                     line_truncated <= 1'b1;
                  end
               end
            end

            S_SEND: begin
               if (pass_end) begin
                  rd_idx <= '0;
                  if (rep < REP_LAST) begin
                     rep   <= rep + CNT_ONE;
                     state <= S_GAP;
                  end else begin
                     wr_len <= '0;
                     rep    <= '0;
                     if (line_cnt == LINE_LAST) begin
                        line_cnt  <= '0;
                        in_solved <= 1'b1;
                        state     <= S_DONE;
                     end else begin
                        // Setting the request wins over a coincident acknowledge of the previous one.
                        line_cnt        <= line_cnt + CNT_ONE;
                        in_require_line <= 1'b1;
                        state           <= S_RECV;
                     end
                  end
               end else if (in_newASCII_ready && lineIn_nextASCII) begin
                  rd_idx <= rd_idx + LEN_ONE;
               end
            end

            S_GAP: state <= S_SEND;

            S_DONE: begin
               if (out_solved) begin
                  in_solved <= 1'b0;
                  state     <= S_RECV;
               end
            end

            default: state <= S_RECV;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_engine.sv
// tb_echo_engine: two echo_engine instances (forward/truncating/multi-line and reverse/repeat)
// checked against a byte scoreboard plus hand-written timing sequences.
module tb_echo_engine;

   localparam int LEN_W = 13;

   logic             clk;
   logic             rst_n;
   logic             in_solved  [2];
   logic             out_solved [2];
   logic             in_req     [2];
   logic             out_req    [2];
   logic             next_in    [2];
   logic             in_ready   [2];
   logic [7:0]       line_in    [2];
   logic             next_out   [2];
   logic             out_ready  [2];
   logic [LEN_W-1:0] out_len    [2];
   logic [7:0]       line_out   [2];
   logic             trunc      [2];

   byte unsigned q0[$];
   byte unsigned q1[$];
   int n_checks = 0;
   int n_errors = 0;

   echo_engine #(.BUFFER_LEN(4), .LEN_W(LEN_W), .LINES(3), .REPEAT(1), .REVERSE(0)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_solved(in_solved[0]), .out_solved(out_solved[0]),
      .in_require_line(in_req[0]), .out_require_line(out_req[0]),
      .lineIn_nextASCII(next_in[0]), .in_newASCII_ready(in_ready[0]), .lineIn(line_in[0]),
      .lineOut_nextASCII(next_out[0]), .out_newASCII_ready(out_ready[0]),
      .out_lineLen(out_len[0]), .lineOut(line_out[0]), .line_truncated(trunc[0])
   );

   echo_engine #(.BUFFER_LEN(8), .LEN_W(LEN_W), .LINES(1), .REPEAT(2), .REVERSE(1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_solved(in_solved[1]), .out_solved(out_solved[1]),
      .in_require_line(in_req[1]), .out_require_line(out_req[1]),
      .lineIn_nextASCII(next_in[1]), .in_newASCII_ready(in_ready[1]), .lineIn(line_in[1]),
      .lineOut_nextASCII(next_out[1]), .out_newASCII_ready(out_ready[1]),
      .out_lineLen(out_len[1]), .lineOut(line_out[1]), .line_truncated(trunc[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic byte unsigned uc(input byte unsigned b);
`ifdef ECHO_UPPERCASE_EN
      if (b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
`endif
      return b;
   endfunction

   task automatic push_byte(input int k, input byte unsigned b);
      if (k == 0) q0.push_back(b);
      else        q1.push_back(b);
   endtask

   // Expected echo: keep at most blen bytes, optionally reverse, repeat with a terminator each pass.
   task automatic push_echo(input int k, input string s, input int blen, input int reps, input bit rev);
      int n;
      n = (s.len() < blen) ? s.len() : blen;
      for (int r = 0; r < reps; r++) begin
         for (int i = 0; i < n; i++) push_byte(k, uc(s[rev ? n - 1 - i : i]));
         push_byte(k, 8'h00);
      end
   endtask

   // Drives bytes (plus terminator) at posedge+1; each byte must be acknowledged in 1 or 2 cycles.
   task automatic send_line(input int k, input string s);
      byte unsigned b;
      int n;
      for (int i = 0; i <= s.len(); i++) begin
         b = (i < s.len()) ? s[i] : 8'h00;
         line_out[k]  = b;
         out_len[k]   = LEN_W'(s.len());
         out_ready[k] = 1'b1;
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!next_out[k] && n < 16);
         check($sformatf("send%0d_ack", k), 32'(next_out[k]), 1);
         check($sformatf("send%0d_latency", k), 32'(n), (i == 0) ? 1 : 2);
      end
      out_ready[k] = 1'b0;
   endtask

   always @(negedge clk) begin
      byte unsigned e;
      if (rst_n && in_ready[0]) begin
         check("a_echo_pending", 32'(q0.size() > 0), 1);
         if (q0.size() > 0) begin
            e = q0.pop_front();
            check("a_echo_byte", 32'(line_in[0]), 32'(e));
         end
      end
   end

   always @(negedge clk) begin
      byte unsigned e;
      if (rst_n && in_ready[1]) begin
         check("b_echo_pending", 32'(q1.size() > 0), 1);
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("b_echo_byte", 32'(line_in[1]), 32'(e));
         end
      end
   end

   typedef struct {
      string line;
      string echo;
      bit    trunc;
      bit    solved;
   } vec_t;

   initial begin
      vec_t     vecs[6];
      int       n;
      bit [8:0] rdy;

      vecs[0] = '{line: "ab",     echo: "ab",   trunc: 1'b0, solved: 1'b0};
      vecs[1] = '{line: "abcdef", echo: "abcd", trunc: 1'b1, solved: 1'b0};
      vecs[2] = '{line: "aZ1",    echo: "aZ1",  trunc: 1'b0, solved: 1'b1};
      vecs[3] = '{line: "",       echo: "",     trunc: 1'b0, solved: 1'b0};
      vecs[4] = '{line: "wxyz",   echo: "wxyz", trunc: 1'b0, solved: 1'b0};
      vecs[5] = '{line: "abcde",  echo: "abcd", trunc: 1'b1, solved: 1'b1};

      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         out_solved[k] = 1'b0;
         out_req[k]    = 1'b0;
         next_in[k]    = 1'b1;
         out_ready[k]  = 1'b0;
         out_len[k]    = '0;
         line_out[k]   = 8'h00;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst%0d_in_solved", k), 32'(in_solved[k]), 0);
         check($sformatf("rst%0d_in_require_line", k), 32'(in_req[k]), 0);
         check($sformatf("rst%0d_in_newASCII_ready", k), 32'(in_ready[k]), 0);
         check($sformatf("rst%0d_lineOut_nextASCII", k), 32'(next_out[k]), 0);
         check($sformatf("rst%0d_line_truncated", k), 32'(trunc[k]), 0);
         check($sformatf("rst%0d_lineIn", k), 32'(line_in[k]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Forward engine: basic echo, overflow, uppercase, empty line, multi-line command flow.
      for (int i = 0; i < 6; i++) begin
         push_echo(0, vecs[i].echo, 64, 1, 1'b0);
         send_line(0, vecs[i].line);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(in_solved[0] || in_req[0]) && n < 80);
         check($sformatf("a%0d_echo_drained", i), 32'(q0.size()), 0);
         check($sformatf("a%0d_in_solved", i), 32'(in_solved[0]), 32'(vecs[i].solved));
         check($sformatf("a%0d_in_require_line", i), 32'(in_req[0]), 32'(!vecs[i].solved));
         check($sformatf("a%0d_line_truncated", i), 32'(trunc[0]), 32'(vecs[i].trunc));
         @(posedge clk); #1;
         if (vecs[i].solved) out_solved[0] = 1'b1;
         else                out_req[0]    = 1'b1;
         @(posedge clk); #1;
         out_solved[0] = 1'b0;
         out_req[0]    = 1'b0;
         check($sformatf("a%0d_ack_solved", i), 32'(in_solved[0]), 0);
         check($sformatf("a%0d_ack_require", i), 32'(in_req[0]), 0);
      end

      // Reverse/repeat engine: two passes of "zyx",00 with exactly one idle cycle between them.
      push_echo(1, "xyz", 8, 2, 1'b1);
      send_line(1, "xyz");
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         rdy[c] = in_ready[1];
      end
      check("b_pass_shape", 32'(rdy), 32'(9'b111101111));
      @(negedge clk);
      check("b_in_solved", 32'(in_solved[1]), 1);
      check("b_ready_after_done", 32'(in_ready[1]), 0);
      check("b_echo_drained", 32'(q1.size()), 0);
      @(posedge clk); #1;
      out_solved[1] = 1'b1;
      @(posedge clk); #1;
      out_solved[1] = 1'b0;
      check("b_ack_solved", 32'(in_solved[1]), 0);

      // Reset in the middle of a send aborts everything, including the truncation flag.
      push_echo(1, "abcdefghij", 8, 2, 1'b1);
      send_line(1, "abcdefghij");
      check("b_overflow_truncated", 32'(trunc[1]), 1);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      q1.delete();
      rst_n = 1'b1;
      check("b_midrst_in_solved", 32'(in_solved[1]), 0);
      check("b_midrst_in_require_line", 32'(in_req[1]), 0);
      check("b_midrst_in_newASCII_ready", 32'(in_ready[1]), 0);
      check("b_midrst_lineOut_nextASCII", 32'(next_out[1]), 0);
      check("b_midrst_line_truncated", 32'(trunc[1]), 0);
      check("b_midrst_lineIn", 32'(line_in[1]), 0);

      // New line after reset, with a two-cycle producer stall at the start of the echo.
      push_echo(1, "pq", 8, 2, 1'b1);
      send_line(1, "pq");
      out_ready[1] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("b_stall_ready", 32'(in_ready[1]), 0);
         check("b_stall_hold", 32'(line_in[1]), 32'(uc(8'h71)));
      end
      @(posedge clk); #1;
      out_ready[1] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_solved[1] && n < 40);
      check("b_post_rst_solved", 32'(in_solved[1]), 1);
      check("b_post_rst_drained", 32'(q1.size()), 0);
      @(posedge clk); #1;
      out_solved[1] = 1'b1;
      @(posedge clk); #1;
      out_solved[1] = 1'b0;
      check("b_post_rst_ack", 32'(in_solved[1]), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
